// File: rtl/mem_access_unit.sv
// M-stage load/store unit: aligns requests onto a word bus, extends load data and stalls the pipeline while a bus transaction is open.
// Optional bus-wait abort: define MEM_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_M,
  input  logic        we_M,
  input  logic [1:0]  size_M,
  input  logic        sext_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_M,
  output logic [31:0] DMout_M,
  output logic        done_M,
  output logic        adel_M,
  output logic        ades_M,
  output logic        bus_err_M
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] dmout_q;
  logic        done_q;
  logic        adel_q;
  logic        ades_q;
  logic        we_q;
  logic        sext_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        misalign_s;
  logic        accept_s;

  // Byte-enable pattern for a naturally aligned access; reserved size behaves as word.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the slave picks whichever lanes are enabled.
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] res;
    case (sz)
      2'b00:   res = {4{wd[7:0]}};
      2'b01:   res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  // Pick the addressed lane out of the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic sx,
                                              input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   res = {{24{sx & b[7]}}, b};
      2'b01:   res = {{16{sx & h[15]}}, h};
      default: res = rd;
    endcase
    return res;
  endfunction

  assign misalign_s = ((size_M == 2'b01) && addr_M[0]) ||
                      (size_M[1] && (addr_M[1:0] != 2'b00));
  assign accept_s   = (state_q == ST_IDLE) && req_M && !misalign_s;
  // Stall is held low while in reset even though it decodes req_M combinationally.
  assign stall_M    = reset && (accept_s || (state_q == ST_REQ));

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             bus_err_q;
`endif

  // Request FSM with all bus and status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      dmout_q     <= 32'h0000_0000;
      done_q      <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      tmo_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      adel_q <= 1'b0;
      ades_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_REQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= we_M;
            bus_addr_q  <= {addr_M[31:2], 2'b00};
            bus_be_q    <= lane_be(size_M, addr_M[1:0]);
            bus_wdata_q <= lane_wdata(size_M, wdata_M);
            we_q        <= we_M;
            sext_q      <= sext_M;
            size_q      <= size_M;
            off_q       <= addr_M[1:0];
`ifdef MEM_TIMEOUT_EN
            tmo_q       <= '0;
`endif
          end else if (req_M) begin
            // Misaligned: report it and never touch the bus.
            adel_q <= !we_M;
            ades_q <= we_M;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            state_q   <= ST_RESP;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            done_q    <= 1'b1;
            if (!we_q) begin
              dmout_q <= load_extend(size_q, sext_q, off_q, bus_rdata);
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q   <= ST_RESP;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`else
          else begin
            state_q <= ST_REQ;
          end
`endif
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign DMout_M   = dmout_q;
  assign done_M    = done_q;
  assign adel_M    = adel_q;
  assign ades_M    = ades_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_err_M = bus_err_q;
`else
  assign bus_err_M = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; expected values are hand-computed per vector.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_M, we_M, sext_M;
  logic [1:0]  size_M;
  logic [31:0] addr_M, wdata_M;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        stall_M, done_M, adel_M, ades_M, bus_err_M;
  logic [31:0] DMout_M;

  int n_chk  = 0;
  int n_pass = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_M(req_M), .we_M(we_M), .size_M(size_M), .sext_M(sext_M),
    .addr_M(addr_M), .wdata_M(wdata_M),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_M(stall_M), .DMout_M(DMout_M), .done_M(done_M),
    .adel_M(adel_M), .ades_M(ades_M), .bus_err_M(bus_err_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One aligned access; dly = extra REQ cycles before the ack cycle.
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int dly, input logic [3:0] ebe, input logic [31:0] ewd,
                     input logic [31:0] edm);
    int stalls;
    stalls = 0;
    req_M = 1'b1; we_M = we; size_M = sz; sext_M = sx; addr_M = a; wdata_M = wd;
    #1;
    if (stall_M) stalls++;
    chk({tag, "_req_pre"}, bus_req, 1'b0);
    step();
    chk({tag, "_req"}, bus_req, 1'b1);
    chk({tag, "_we"}, bus_we, we);
    chk({tag, "_addr"}, bus_addr, a & 32'hFFFF_FFFC);
    chk({tag, "_be"}, bus_be, ebe);
    chk({tag, "_wdata"}, bus_wdata, ewd);
    for (int i = 0; i < dly; i++) begin
      if (stall_M) stalls++;
      step();
    end
    chk({tag, "_req_hold"}, bus_req, 1'b1);
    chk({tag, "_be_hold"}, bus_be, ebe);
    if (stall_M) stalls++;
    bus_ack = 1'b1; bus_rdata = rd;
    step();
    bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    chk({tag, "_done"}, done_M, 1'b1);
    chk({tag, "_dm"}, DMout_M, edm);
    chk({tag, "_req_off"}, bus_req, 1'b0);
    chk({tag, "_stall_resp"}, stall_M, 1'b0);
    chk({tag, "_err"}, bus_err_M, 1'b0);
    chk({tag, "_stalls"}, stalls, dly + 2);
    step();
    req_M = 1'b0;
    #1;
    chk({tag, "_done_off"}, done_M, 1'b0);
    chk({tag, "_idle_req"}, bus_req, 1'b0);
  endtask

  initial begin
    reset = 1'b0; req_M = 1'b0; we_M = 1'b0; size_M = 2'b00; sext_M = 1'b0;
    addr_M = 32'h0; wdata_M = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_req", bus_req, 1'b0);
    chk("rst_stall", stall_M, 1'b0);
    chk("rst_done", done_M, 1'b0);
    chk("rst_dm", DMout_M, 32'h0);
    chk("rst_be", bus_be, 4'b0000);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_err", bus_err_M, 1'b0);
    reset = 1'b1;
    step();

    txn("lb_sx",   1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h80FF_FF00, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
    txn("sh",      1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_ABCD, 32'h5555_5555, 2, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80);
    txn("lhu",     1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 32'h8001_1234, 0, 4'b1100, 32'h0, 32'h0000_8001);
    txn("sb",      1'b1, 2'b00, 1'b0, 32'h01, 32'h0000_00A5, 32'h0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8001);
    txn("lw",      1'b0, 2'b10, 1'b1, 32'h04, 32'h0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    txn("lbu",     1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_9A00, 0, 4'b0010, 32'h0, 32'h0000_009A);
    txn("lrsv",    1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 32'h1122_3344, 0, 4'b1111, 32'h0, 32'h1122_3344);

    // Stray ack in IDLE must be ignored
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    step();
    bus_ack = 1'b0;
    chk("stray_done", done_M, 1'b0);
    chk("stray_dm", DMout_M, 32'h1122_3344);

    // Misaligned word load
    req_M = 1'b1; we_M = 1'b0; size_M = 2'b10; addr_M = 32'h06;
    #1;
    chk("mis_lw_stall", stall_M, 1'b0);
    step();
    chk("mis_lw_adel", adel_M, 1'b1);
    chk("mis_lw_ades", ades_M, 1'b0);
    chk("mis_lw_req", bus_req, 1'b0);
    req_M = 1'b0;
    step();
    chk("mis_lw_adel_off", adel_M, 1'b0);

    // Misaligned half store
    req_M = 1'b1; we_M = 1'b1; size_M = 2'b01; addr_M = 32'h01;
    step();
    chk("mis_sh_ades", ades_M, 1'b1);
    chk("mis_sh_adel", adel_M, 1'b0);
    chk("mis_sh_req", bus_req, 1'b0);
    req_M = 1'b0;
    step();

    // Reset in the middle of a word load
    req_M = 1'b1; we_M = 1'b0; size_M = 2'b10; addr_M = 32'h08;
    step();
    chk("rmid_req", bus_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("rmid_req_drop", bus_req, 1'b0);
    chk("rmid_stall", stall_M, 1'b0);
    chk("rmid_dm", DMout_M, 32'h0);
    req_M = 1'b0;
    step();
    reset = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    begin
      int dn;
      dn = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        bus_ack = 1'b0;
        if (done_M) dn++;
      end
      chk("rmid_no_done", dn, 0);
    end
    chk("rmid_dm_after", DMout_M, 32'h0);

    // Bus never answers
    req_M = 1'b1; we_M = 1'b0; size_M = 2'b10; addr_M = 32'h0C;
    step();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    chk("tmo_not_yet", done_M, 1'b0);
    chk("tmo_stall", stall_M, 1'b1);
    step();
    chk("tmo_done", done_M, 1'b1);
    chk("tmo_err", bus_err_M, 1'b1);
    chk("tmo_dm", DMout_M, 32'h0);
    req_M = 1'b0;
    step();
    chk("tmo_err_off", bus_err_M, 1'b0);
    chk("tmo_idle_stall", stall_M, 1'b0);
`else
    for (int i = 0; i < 20; i++) step();
    chk("wait_stall", stall_M, 1'b1);
    chk("wait_req", bus_req, 1'b1);
    chk("wait_done", done_M, 1'b0);
    chk("wait_err", bus_err_M, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ack = 1'b0;
    chk("wait_fin_done", done_M, 1'b1);
    chk("wait_fin_dm", DMout_M, 32'hCAFE_F00D);
    req_M = 1'b0;
    step();
`endif
    chk("end_idle_req", bus_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
